// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encoding, operand-mode constants and the step-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Width needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_addsub.sv
// Combinational add/subtract used for one multiplier step.
// The operands are one bit wider than the multiplier operands, so adding or
// subtracting a sign-extended multiplicand never overflows. cout is the carry
// out of the full-width add; it only has meaning when sub=0.
module mul_addsub #(
  parameter int DW = 33
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] sum,
  output logic          cout
);

  logic [DW-1:0] b_eff_s;

  // Two's-complement subtract: invert b and inject a carry-in of one.
  always_comb begin
    b_eff_s = b;
    if (sub) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    {cout, sum} = {1'b0, a} + {1'b0, b_eff_s} + {{DW{1'b0}}, sub};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// One add/shift step per clock; signed or unsigned chosen per operation.
// Handshake: Busy while iterating, Rdy while a result is presented on Prod.
// Optional build macro MUL_ZERO_BYPASS_EN: when defined, a load with a zero
// operand skips the iteration and presents a zero product one cycle later.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Run,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Mult,
  input  logic [WIDTH-1:0]     Mul,
  output logic [2*WIDTH-1:0]   Prod,
  output logic                 Rdy,
  output logic                 Busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   mcand_r;
  logic [WIDTH:0]   hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             mode_r;
  logic             rdy_r;
  logic             busy_r;

  logic             last_s;
  logic             sub_s;
  logic [WIDTH:0]   as_sum_s;
  logic             as_cout_s;
  logic [WIDTH:0]   step_hi_s;
  logic             step_carry_s;
  logic             step_msb_s;
  logic [WIDTH:0]   mcand_ext_s;

`ifdef MUL_ZERO_BYPASS_EN
  logic             zero_op_s;

  // Detect a zero operand at load time so the iteration can be skipped.
  always_comb begin
    zero_op_s = 1'b0;
    if ((Mult == {WIDTH{1'b0}}) || (Mul == {WIDTH{1'b0}})) begin
      zero_op_s = 1'b1;
    end else begin
      zero_op_s = 1'b0;
    end
  end
`endif

  // The final step of a signed operation weighs the multiplier MSB negatively.
  always_comb begin
    last_s = (cnt_r == LAST_STEP);
    sub_s  = 1'b0;
    if ((mode_r == MODE_SIGNED) && last_s) begin
      sub_s = 1'b1;
    end else begin
      sub_s = 1'b0;
    end
  end

  mul_addsub #(
    .DW(WIDTH + 1)
  ) u_addsub (
    .a    (hi_r),
    .b    (mcand_r),
    .sub  (sub_s),
    .sum  (as_sum_s),
    .cout (as_cout_s)
  );

  // Select the pre-shift high half and the bit shifted into its MSB.
  always_comb begin
    step_hi_s    = hi_r;
    step_carry_s = 1'b0;
    step_msb_s   = 1'b0;
    if (lo_r[0]) begin
      step_hi_s    = as_sum_s;
      step_carry_s = as_cout_s;
    end else begin
      step_hi_s    = hi_r;
      step_carry_s = 1'b0;
    end
    if (mode_r == MODE_SIGNED) begin
      step_msb_s = step_hi_s[WIDTH];
    end else begin
      step_msb_s = step_carry_s;
    end
  end

  // Extend the multiplicand by one bit according to the requested mode.
  always_comb begin
    mcand_ext_s = {1'b0, Mult};
    if (Signed == MODE_SIGNED) begin
      mcand_ext_s = {Mult[WIDTH-1], Mult};
    end else begin
      mcand_ext_s = {1'b0, Mult};
    end
  end

  // Control FSM and datapath registers; Rdy/Busy are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      mcand_r <= {(WIDTH + 1){1'b0}};
      hi_r    <= {(WIDTH + 1){1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      mode_r  <= MODE_UNSIGNED;
      rdy_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Run) begin
            mcand_r <= mcand_ext_s;
            hi_r    <= {(WIDTH + 1){1'b0}};
            lo_r    <= Mul;
            mode_r  <= Signed;
            cnt_r   <= {CNT_W{1'b0}};
            rdy_r   <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_op_s) begin
              lo_r    <= {WIDTH{1'b0}};
              state_r <= DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= CALC;
              busy_r  <= 1'b1;
            end
`else
            state_r <= CALC;
            busy_r  <= 1'b1;
`endif
          end else if (state_r == DONE) begin
            rdy_r  <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            rdy_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          hi_r  <= {step_msb_s, step_hi_s[WIDTH:1]};
          lo_r  <= {step_hi_s[0], lo_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            state_r <= DONE;
            rdy_r   <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CALC;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Product is only visible once the operation has completed.
  always_comb begin
    Prod = {(2 * WIDTH){1'b0}};
    if (state_r == DONE) begin
      Prod = {hi_r[WIDTH-1:0], lo_r};
    end else begin
      Prod = {(2 * WIDTH){1'b0}};
    end
  end

  assign Rdy  = rdy_r;
  assign Busy = busy_r;

endmodule
